hamming_decoder_stream: RTL and testbench

Streaming Hamming(7,4) single-error-correcting decoder. It sits directly downstream of the Hamming encoder and the channel, and consumes 7-bit codewords in the encoder's bit layout. It returns the corrected 4-bit data through a two-stage valid/ready pipeline, with a per-word error flag, the syndrome, and saturating word and correction counters.

---
 rtl/hamming_decoder_stream.sv | 108 ++++++++++
 tb/tb_hamming_decoder_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder_stream.sv
// Streaming Hamming(7,4) SEC decoder: two-stage valid/ready pipeline
// (S1 = codeword + syndrome, S2 = corrected data + flags) with saturating
// word / correction statistics.
`timescale 1ns/1ps
module hamming_decoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       ham_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       data,
    output logic             err_flag,
    output logic [2:0]       err_pos,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [6:0] code;
        logic [2:0] syn;
    } s1_t;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
        logic [2:0] pos;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    logic            s1_ld, s2_ld, out_hs;
    logic [6:0]      flip, fix_code;

    // S2 drains when empty or downstream takes it; S1 follows S2.
    assign s2_ld    = !vld_pipe[2] || out_ready;
    assign s1_ld    = !vld_pipe[1] || s2_ld;
    assign in_ready = s1_ld;
    assign out_hs   = vld_pipe[2] && out_ready;

    // Syndrome of the incoming word, captured alongside it in S1.
    always_comb begin
        s1_d.code   = ham_data;
        s1_d.syn[0] = ham_data[0] ^ ham_data[2] ^ ham_data[4] ^ ham_data[6];
        s1_d.syn[1] = ham_data[1] ^ ham_data[2] ^ ham_data[5] ^ ham_data[6];
        s1_d.syn[2] = ham_data[3] ^ ham_data[4] ^ ham_data[5] ^ ham_data[6];
    end

    // Flip the bit named by the syndrome and pull out the data positions.
    always_comb begin
        flip = '0;
        if (s1_q.syn != 3'd0)
            flip[s1_q.syn - 3'd1] = 1'b1;
        fix_code  = s1_q.code ^ flip;
        s2_d.data = {fix_code[6], fix_code[5], fix_code[4], fix_code[2]};
        s2_d.err  = |s1_q.syn;
        s2_d.pos  = s1_q.syn;
    end

    // Stage 1: payload only captured on an input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            s1_q        <= '0;
        end else if (s1_ld) begin
            vld_pipe[1] <= in_valid;
            if (in_valid)
                s1_q <= s1_d;
        end
    end

    // Stage 2: holds outputs stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            s2_q        <= '0;
        end else if (s2_ld) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1])
                s2_q <= s2_d;
        end
    end

    // Saturating statistics; clear wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (out_hs) begin
            if (word_cnt != '1)
                word_cnt <= word_cnt + 1'b1;
            if (s2_q.err && corr_cnt != '1)
                corr_cnt <= corr_cnt + 1'b1;
        end
    end

    assign out_valid = vld_pipe[2];
    assign data      = s2_q.data;
    assign err_flag  = s2_q.err;
    assign err_pos   = s2_q.pos;

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Scoreboard bench for hamming_decoder_stream: a 16-bit-counter instance
// for data checks and a 4-bit-counter instance sharing the same stimulus
// for saturation checks.
`timescale 1ns/1ps
module tb_hamming_decoder_stream;

    typedef struct packed {
        logic [3:0] d;
        logic       e;
        logic [2:0] p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, clr_cnt;
    logic [6:0]  ham_data;
    logic [3:0]  data;
    logic        err_flag;
    logic [2:0]  err_pos;
    logic [15:0] word_cnt, corr_cnt;

    logic        in_ready4, out_valid4, err_flag4;
    logic [3:0]  data4;
    logic [2:0]  err_pos4;
    logic [3:0]  word_cnt4, corr_cnt4;

    logic        or_fix, rnd_mode, rnd_bit;
    exp_t        exp_cur;
    exp_t        q[$];
    int          n_chk = 0, n_err = 0, cyc = 0;
    logic        lat_arm, acc_seen, out_seen;
    int          acc_cyc, out_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign out_ready = rnd_mode ? rnd_bit : or_fix;

    hamming_decoder_stream #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ham_data(ham_data), .in_valid(in_valid),
        .in_ready(in_ready), .data(data), .err_flag(err_flag), .err_pos(err_pos),
        .out_valid(out_valid), .out_ready(out_ready), .clr_cnt(clr_cnt),
        .word_cnt(word_cnt), .corr_cnt(corr_cnt)
    );

    hamming_decoder_stream #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ham_data(ham_data), .in_valid(in_valid),
        .in_ready(in_ready4), .data(data4), .err_flag(err_flag4), .err_pos(err_pos4),
        .out_valid(out_valid4), .out_ready(out_ready), .clr_cnt(clr_cnt),
        .word_cnt(word_cnt4), .corr_cnt(corr_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [6:0] c, input logic [3:0] d, input logic e, input logic [2:0] p);
        logic acc;
        ham_data = c;
        exp_cur  = '{d: d, e: e, p: p};
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #1 acc = in_ready;
            @(negedge clk);
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("send_timeout", 32'd1, 32'd0);
    endtask

    // Returns at falling edge + 2 once the pipeline and scoreboard are empty.
    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            #2 if (q.size() == 0 && !out_valid) done = 1'b1;
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic clr_idle();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #2;
        check("clr_word", 32'(word_cnt), 32'd0);
        check("clr_corr", 32'(corr_cnt), 32'd0);
        check("clr_word4", 32'(word_cnt4), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: push on input handshake, compare head while out_valid, pop on output handshake.
    initial begin
        acc_seen = 1'b0;
        out_seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                q.delete();
            end else begin
                if (lat_arm && out_valid && !out_seen) begin
                    out_seen = 1'b1;
                    out_cyc  = cyc;
                end
                if (in_valid && in_ready) begin
                    q.push_back(exp_cur);
                    if (lat_arm && !acc_seen) begin
                        acc_seen = 1'b1;
                        acc_cyc  = cyc;
                    end
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_out", 32'd1, 32'd0);
                    end else begin
                        check("data", 32'(data), 32'(q[0].d));
                        check("err_flag", 32'(err_flag), 32'(q[0].e));
                        check("err_pos", 32'(err_pos), 32'(q[0].p));
                        if (out_ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k, ov;
        logic acc;
        logic [6:0] c;
        rst = 1'b1; in_valid = 1'b0; ham_data = '0; clr_cnt = 1'b0;
        or_fix = 1'b1; rnd_mode = 1'b0; exp_cur = '0; lat_arm = 1'b0;

        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_err_pos", 32'(err_pos), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_word", 32'(word_cnt), 32'd0);
        check("rst_corr", 32'(corr_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Error-free stream, back to back
        lat_arm = 1'b1;
        for (int d = 0; d < 16; d++) send(enc(4'(d)), 4'(d), 1'b0, 3'd0);
        wait_drain();
        lat_arm = 1'b0;
        check("lat_seen", 32'(acc_seen & out_seen), 32'd1);
        check("latency", 32'(out_cyc - acc_cyc), 32'd2);
        check("ef_word", 32'(word_cnt), 32'd16);
        check("ef_corr", 32'(corr_cnt), 32'd0);
        check("ef_word4_sat", 32'(word_cnt4), 32'd15);
        @(negedge clk);

        // Parity-bit error and documented example
        send(7'h01, 4'h0, 1'b1, 3'd1);
        send(7'h45, 4'hB, 1'b1, 3'd5);
        wait_drain();
        @(negedge clk);
        clr_idle();

        // Single-error sweep
        for (int d = 0; d < 16; d++)
            for (int b = 0; b < 7; b++) begin
                c = enc(4'(d)) ^ (7'd1 << b);
                send(c, 4'(d), 1'b1, 3'(b + 1));
            end
        wait_drain();
        check("sw_corr", 32'(corr_cnt), 32'd112);
        check("sw_word", 32'(word_cnt), 32'd112);
        check("sw_corr4_sat", 32'(corr_cnt4), 32'd15);
        @(negedge clk);
        clr_idle();

        // Backpressure: out_ready low for 5 cycles with input offered
        or_fix = 1'b0;
        k = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ham_data = enc(4'(k));
            exp_cur  = '{d: 4'(k), e: 1'b0, p: 3'd0};
            #1 acc = in_ready;
            if (i == 4) begin
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_out_valid", 32'(out_valid), 32'd1);
            end
            @(negedge clk);
            if (acc) k++;
        end
        check("bp_accepted", 32'(k), 32'd2);
        rnd_mode = 1'b1;
        for (int j = k; j < 12; j++) begin
            if (j % 2 == 1) send(enc(4'(j)) ^ (7'd1 << (j % 7)), 4'(j), 1'b1, 3'((j % 7) + 1));
            else            send(enc(4'(j)), 4'(j), 1'b0, 3'd0);
        end
        wait_drain();
        rnd_mode = 1'b0;
        or_fix   = 1'b1;
        check("bp_word", 32'(word_cnt), 32'd12);
        check("bp_corr", 32'(corr_cnt), 32'd5);
        @(negedge clk);
        clr_idle();

        // Saturation of the 4-bit counters
        for (int j = 0; j < 20; j++) send(enc(4'(j)), 4'(j), 1'b0, 3'd0);
        wait_drain();
        check("sat_word4", 32'(word_cnt4), 32'd15);
        check("sat_word", 32'(word_cnt), 32'd20);
        @(negedge clk);

        // Clear in the same cycle as an output handshake
        or_fix = 1'b0;
        send(enc(4'd5), 4'd5, 1'b0, 3'd0);
        @(negedge clk);
        #1 check("clrhs_pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        clr_cnt = 1'b1;
        or_fix  = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #2;
        check("clrhs_word", 32'(word_cnt), 32'd0);
        check("clrhs_corr", 32'(corr_cnt), 32'd0);
        check("clrhs_word4", 32'(word_cnt4), 32'd0);
        check("clrhs_drained", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Reset with two words in flight
        send(enc(4'd1), 4'd1, 1'b0, 3'd0);
        wait_drain();
        check("pre_rst_word", 32'(word_cnt), 32'd1);
        @(negedge clk);
        or_fix = 1'b0;
        send(enc(4'd3), 4'd3, 1'b0, 3'd0);
        send(enc(4'd9), 4'd9, 1'b0, 3'd0);
        #1 check("inflight_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_word", 32'(word_cnt), 32'd0);
        check("mr_corr", 32'(corr_cnt), 32'd0);
        @(negedge clk);
        or_fix = 1'b1;
        ov = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2 if (out_valid) ov++;
        end
        check("mr_no_stale", 32'(ov), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
